// File: rtl/sprite_line_fetch_pkg.sv
// Shared sprite pipeline definitions: fetch sequencer states and line timing constants.
// Imported by the fetch sequencer, its bus interface and the sprite manager.
package sprite_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_ADDR,
        FETCH_WAIT,
        FETCH_STROBE,
        FETCH_DONE
    } fetch_state_t;

    localparam int H_ACTIVE  = 640;
    localparam int SORT_TIME = 64;
    // Fetch starts once the visible area and the slot sort have both finished.
    localparam int FETCH_START_COL = H_ACTIVE + SORT_TIME;

    function automatic int sel_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/sprite_line_fetch_if.sv
// Bus between the line-fetch sequencer (master) and the sprite manager (slave).
// The overrun flag exists only when SPRITE_FETCH_OVERRUN_EN is defined.
interface sprite_line_fetch_if #(
    parameter int NUM_SLOTS      = 8,
    parameter int WORDS_PER_LINE = 2,
    parameter int COL_W          = 12,
    parameter int IDX_W          = $clog2(NUM_SLOTS + 1)
);
    import sprite_pkg::*;

    localparam int SEL_W = sel_width(WORDS_PER_LINE);

    // Handshake: slot_index/word_sel are stable from the address cycle through the
    // strobe; word_valid is a one-hot, one-cycle strobe with no ready/backpressure,
    // so the consumer must take the RAM data in exactly that cycle.
    logic [COL_W-1:0]          pix_col;
    logic                      enable;
    logic [IDX_W-1:0]          slot_index;
    logic [SEL_W-1:0]          word_sel;
    logic [WORDS_PER_LINE-1:0] word_valid;
    logic                      busy;
    logic                      line_done;
`ifdef SPRITE_FETCH_OVERRUN_EN
    logic                      overrun;
`endif
    fetch_state_t              dbg_state;

    modport master (
        input  pix_col, enable,
`ifdef SPRITE_FETCH_OVERRUN_EN
        output overrun,
`endif
        output slot_index, word_sel, word_valid, busy, line_done, dbg_state
    );

    modport slave (
        output pix_col, enable,
`ifdef SPRITE_FETCH_OVERRUN_EN
        input  overrun,
`endif
        input  slot_index, word_sel, word_valid, busy, line_done, dbg_state
    );

endinterface

// File: rtl/sprite_line_fetch_latency_ctr.sv
// Loadable down-counter with terminal-count flag; times the RAM read-latency wait.
module fetch_latency_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite graphics fetch sequencer: walks every slot/word in h-blank.
// Optional sticky abort flag: define SPRITE_FETCH_OVERRUN_EN to add bus.overrun.
module sprite_line_fetch #(
    parameter int NUM_SLOTS      = 8,
    parameter int WORDS_PER_LINE = 2,
    parameter int READ_LATENCY   = 3,
    parameter int COL_W          = 12,
    parameter int START_COL      = sprite_pkg::FETCH_START_COL,
    parameter int IDX_W          = $clog2(NUM_SLOTS + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    sprite_line_fetch_if.master bus
);
    import sprite_pkg::*;

    localparam int SEL_W = sel_width(WORDS_PER_LINE);
    localparam int LAT_W = 4;
    // WAIT lasts READ_LATENCY-1 cycles: load N-2 and leave when the counter hits 0.
    localparam logic [LAT_W-1:0] WAIT_LOAD = (READ_LATENCY > 1) ? LAT_W'(READ_LATENCY - 2) : '0;
    localparam logic [IDX_W-1:0] IDLE_IDX  = IDX_W'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);
    localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(WORDS_PER_LINE - 1);
    localparam logic [COL_W-1:0] TRIG_COL  = COL_W'(START_COL);

    fetch_state_t              r_state;
    logic [IDX_W-1:0]          r_slot;
    logic [SEL_W-1:0]          r_word;
    logic [WORDS_PER_LINE-1:0] r_word_valid;
    logic                      r_busy;
    logic                      r_line_done;

    logic                      w_trigger;
    logic                      w_abort;
    logic                      w_last_word;
    logic                      w_last_slot;
    logic                      w_to_done;
    logic                      w_lat_tc;
    logic [WORDS_PER_LINE-1:0] w_word_onehot;

    assign w_trigger     = bus.enable && (bus.pix_col == TRIG_COL);
    assign w_abort       = (r_state != FETCH_IDLE) && (bus.pix_col == '0);
    assign w_last_word   = (r_word == LAST_WORD);
    assign w_last_slot   = (r_slot == LAST_SLOT);
    assign w_to_done     = (r_state == FETCH_STROBE) && w_last_word && w_last_slot && !w_abort;
    assign w_word_onehot = WORDS_PER_LINE'(1) << r_word;

    fetch_latency_ctr #(.W(LAT_W)) u_lat (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (r_state == FETCH_ADDR),
        .i_load_val (WAIT_LOAD),
        .i_dec      (r_state == FETCH_WAIT),
        .o_tc       (w_lat_tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= FETCH_IDLE;
            r_slot       <= IDLE_IDX;
            r_word       <= '0;
            r_word_valid <= '0;
            r_busy       <= 1'b0;
            r_line_done  <= 1'b0;
        end else begin
            r_word_valid <= '0;
            r_line_done  <= 1'b0;
            if (w_abort) begin
                r_state <= FETCH_IDLE;
                r_slot  <= IDLE_IDX;
                r_word  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    FETCH_IDLE: begin
                        if (w_trigger) begin
                            r_state <= FETCH_ADDR;
                            r_slot  <= '0;
                            r_word  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    FETCH_ADDR: begin
                        if (READ_LATENCY > 1) begin
                            r_state <= FETCH_WAIT;
                        end else begin
                            r_state      <= FETCH_STROBE;
                            r_word_valid <= w_word_onehot;
                        end
                    end
                    FETCH_WAIT: begin
                        if (w_lat_tc) begin
                            r_state      <= FETCH_STROBE;
                            r_word_valid <= w_word_onehot;
                        end
                    end
                    FETCH_STROBE: begin
                        // Counters only advance below their terminal values, so they saturate.
                        if (!w_last_word) begin
                            r_word  <= r_word + SEL_W'(1);
                            r_state <= FETCH_ADDR;
                        end else if (!w_last_slot) begin
                            r_word  <= '0;
                            r_slot  <= r_slot + IDX_W'(1);
                            r_state <= FETCH_ADDR;
                        end else begin
                            r_state     <= FETCH_DONE;
                            r_line_done <= 1'b1;
                        end
                    end
                    FETCH_DONE: begin
                        r_state <= FETCH_IDLE;
                        r_slot  <= IDLE_IDX;
                        r_word  <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= FETCH_IDLE;
                endcase
            end
        end
    end

`ifdef SPRITE_FETCH_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
        end else if (w_abort) begin
            r_overrun <= 1'b1;
        end else if (w_to_done) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.overrun = r_overrun;
`endif

    assign bus.slot_index = r_slot;
    assign bus.word_sel   = r_word;
    assign bus.word_valid = r_word_valid;
    assign bus.busy       = r_busy;
    assign bus.line_done  = r_line_done;
    assign bus.dbg_state  = r_state;

endmodule
